// File: rtl/nanov_mmio_ctrl_pkg.sv
// Shared definitions for the nanoV MMIO controller: default peripheral
// addresses, status register bit positions, drain FSM states and a
// helper for the CPU's bit-reversed write data.
package nanov_mmio_ctrl_pkg;

  localparam logic [31:0] DEF_GPIO_ADDR      = 32'h1000_0000;
  localparam logic [31:0] DEF_UART_DATA_ADDR = 32'h1000_1000;
  localparam logic [31:0] DEF_UART_STAT_ADDR = 32'h1000_1004;

  // Bit positions inside the UART status word
  localparam int STAT_TX_ACTIVE = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_OVF       = 2;
  localparam int STAT_EMPTY     = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT_RISE,
    ST_WAIT_FALL
  } drain_state_t;

  // The CPU presents write data MSB-first on the bus
  function automatic logic [31:0] bit_reverse(input logic [31:0] value);
    logic [31:0] result;
    for (int i = 0; i < 32; i++) begin
      result[i] = value[31-i];
    end
    return result;
  endfunction

endpackage

// File: rtl/nanov_mmio_ctrl_if.sv
// CPU-side strobe bus of the nanoV core as seen by the MMIO controller.
interface nanov_mmio_ctrl_if;

  logic        is_addr;
  logic        is_data;
  logic [31:0] bus_out;
  logic [31:0] bus_in;

  modport master (output is_addr, output is_data, output bus_out, input bus_in);
  modport slave  (input is_addr, input is_data, input bus_out, output bus_in);

endinterface

// File: rtl/nanov_mmio_ctrl_fifo.sv
// Synchronous circular-buffer FIFO. A push while full is accepted only
// when a pop happens in the same cycle; pops on an empty FIFO are ignored.
module nanov_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_wdata,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_rdata,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == FULL_COUNT);
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Storage write; entries are only meaningful between the pointers
  // NOTE: the memory array is deliberately not reset -- the pointers and
  // count define validity, and leaving it out keeps it mappable to RAM.
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block evaluation order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/nanov_mmio_ctrl.sv
// nanoV memory-mapped peripheral controller: latches the peripheral select
// on each address phase, handles LED/GPIO writes and read-back, and queues
// UART transmit bytes in a FIFO drained onto the uart_tx serialiser.
module nanov_mmio_ctrl
  import nanov_mmio_ctrl_pkg::*;
#(
  parameter logic [31:0] GPIO_ADDR      = DEF_GPIO_ADDR,
  parameter logic [31:0] UART_DATA_ADDR = DEF_UART_DATA_ADDR,
  parameter logic [31:0] UART_STAT_ADDR = DEF_UART_STAT_ADDR,
  parameter int          FIFO_DEPTH     = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  nanov_mmio_ctrl_if.slave        cpu,
  input  logic [2:0]              i_buttons,
  output logic [31:0]             o_led_data,
  output logic                    o_uart_tx_en,
  output logic [7:0]              o_uart_tx_data,
  input  logic                    i_uart_tx_busy
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          r_sel_gpio;
  logic          r_sel_udata;
  logic          r_sel_ustat;
  logic [31:0]   r_led_data;
  logic          r_ovf;
  logic          r_rise_wait;
  drain_state_t  r_state;
  drain_state_t  w_next_state;
  logic [31:0]   w_wdata;
  logic          w_push;
  logic          w_pop;
  logic          w_fifo_full;
  logic          w_fifo_empty;
  logic [7:0]    w_fifo_head;
  logic [CW-1:0] w_fifo_count;
  logic          w_tx_active;

  assign w_wdata     = bit_reverse(cpu.bus_out);
  assign w_push      = cpu.is_data && r_sel_udata;
  assign w_tx_active = !w_fifo_empty || (r_state != ST_IDLE) || i_uart_tx_busy;
  assign o_led_data  = r_led_data;

  nanov_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_wdata (w_wdata[7:0]),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  // Peripheral select, loaded from an exact address compare on each address phase
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sel_gpio  <= 1'b0;
      r_sel_udata <= 1'b0;
      r_sel_ustat <= 1'b0;
    end else if (cpu.is_addr) begin
      r_sel_gpio  <= (cpu.bus_out == GPIO_ADDR);
      r_sel_udata <= (cpu.bus_out == UART_DATA_ADDR);
      r_sel_ustat <= (cpu.bus_out == UART_STAT_ADDR);
    end
  end

  // LED register write and sticky overflow flag; both use the pre-edge select
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_led_data <= '0;
      r_ovf      <= 1'b0;
    end else begin
      if (cpu.is_data && r_sel_gpio) begin
        r_led_data <= w_wdata;
      end
      if (cpu.is_data && r_sel_ustat) begin
        r_ovf <= 1'b0;
      end else if (w_push && w_fifo_full && !w_pop) begin
        r_ovf <= 1'b1;
      end
    end
  end

  // Drain FSM state register plus the WAIT_RISE timeout marker
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_rise_wait <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_rise_wait <= (r_state == ST_WAIT_RISE) && (w_next_state == ST_WAIT_RISE);
    end
  end

  // Drain FSM next state and serialiser handshake
  // NOTE: every output of this block is given a default before the case so
  // no path leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next_state   = r_state;
    o_uart_tx_en   = 1'b0;
    o_uart_tx_data = '0;
    w_pop          = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if ((w_fifo_count != '0) && !i_uart_tx_busy) w_next_state = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        o_uart_tx_en   = 1'b1;
        o_uart_tx_data = w_fifo_head;
        w_pop          = 1'b1;
        w_next_state   = ST_WAIT_RISE;
      end
      ST_WAIT_RISE: begin
        // Give up after two cycles so a serialiser that never answers cannot stall the queue
        if (i_uart_tx_busy)   w_next_state = ST_WAIT_FALL;
        else if (r_rise_wait) w_next_state = ST_IDLE;
      end
      ST_WAIT_FALL: begin
        if (!i_uart_tx_busy) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Read-data mux, driven purely from the latched select
  always_comb begin
    cpu.bus_in = '0;
    if (r_sel_gpio) begin
      cpu.bus_in[2:0] = i_buttons;
    end else if (r_sel_ustat) begin
      cpu.bus_in[STAT_TX_ACTIVE] = w_tx_active;
      cpu.bus_in[STAT_FULL]      = w_fifo_full;
      cpu.bus_in[STAT_OVF]       = r_ovf;
      cpu.bus_in[STAT_EMPTY]     = w_fifo_empty;
    end
  end

endmodule

// File: doc/nanov_mmio_ctrl.md
# nanoV_mmio_ctrl

Memory-mapped peripheral controller between the nanoV CPU bus strobes and the on-board peripherals. It latches the peripheral select on each address phase and drives GPIO/LED writes and the read-data mux. It buffers UART transmit bytes in a small FIFO and schedules them onto the `uart_tx` serialiser, so software no longer has to poll busy before every byte. It sits in the top level between `nanoV_cpu` and `uart_tx`/`LedScan`.

## Interface
- `GPIO_ADDR`, 32'h10000000, LED write / button read address
- `UART_DATA_ADDR`, 32'h10001000, UART transmit data address
- `UART_STAT_ADDR`, 32'h10001004, UART status address
- `FIFO_DEPTH`, 4, TX FIFO entries; power of two, 2..16

- `clk`  in  1  CPU clock; one clock domain, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `is_addr`  in  1  CPU address-phase strobe
- `is_data`  in  1  CPU data-phase (write) strobe
- `bus_out`  in  32  CPU `data_out`; address unreversed, write data bit-reversed
- `bus_in`  out  32  read data to CPU `data_in`
- `buttons`  in  3  {button3, button2, button1}
- `led_data`  out  32  LED pattern to `LedScan`
- `uart_tx_en`  out  1  one-cycle start pulse to `uart_tx`
- `uart_tx_data`  out  8  byte to `uart_tx`
- `uart_tx_busy`  in  1  serialiser busy

## Operation
- Select latch: on `is_addr`, the one-hot select `{sel_gpio, sel_udata, sel_ustat}` is loaded from an exact compare of `bus_out` against the three addresses. A non-matching address clears all three bits. Without `is_addr` the select holds.
- Write data: `wdata = bit-reverse(bus_out)`.
- `is_data` & `sel_gpio`: `led_data <= wdata`.
- `is_data` & `sel_udata`: push `wdata[7:0]` into the FIFO.
  - Push when full with no pop in the same cycle: the byte is dropped and sticky `ovf` is set.
  - Push and pop in the same cycle when full: the push is accepted and the count is unchanged.
- `is_data` & `sel_ustat`: clears `ovf`. Data is ignored.
- Read mux (combinational from the select registers):
  - `sel_gpio`: `{29'b0, buttons}`
  - `sel_ustat`: `{28'b0, fifo_empty, ovf, fifo_full, tx_active}`
  - otherwise: 0
- `tx_active` = FIFO non-empty | state != IDLE | `uart_tx_busy`.
- Drain FSM:
  - IDLE → LAUNCH when FIFO non-empty and `!uart_tx_busy`.
  - LAUNCH (1 cycle): `uart_tx_en=1`, `uart_tx_data` = head, pop. Next state WAIT_RISE.
  - WAIT_RISE: go to WAIT_FALL when `uart_tx_busy=1`. If busy has not risen after 2 cycles in this state, go to IDLE (guard).
  - WAIT_FALL: go to IDLE when `uart_tx_busy=0`.
- FIFO: circular buffer with read/write pointers of log2(FIFO_DEPTH) bits that wrap modulo depth, plus a count of width log2(FIFO_DEPTH)+1.

## Timing
- Reset values:
  - `led_data`=0, `uart_tx_en`=0, `uart_tx_data`=0.
  - Select registers 0, so `bus_in`=0.
  - FIFO empty, `ovf`=0, FSM IDLE.
- Reset mid-transmit: FIFO contents are discarded. A byte already handed to `uart_tx` completes under that module's own reset.
- Select is usable on the cycle after `is_addr`.
- `led_data` updates the cycle after `is_data`.
- `bus_in` is valid one cycle after `is_addr` and is held while the select holds.
- Push-to-start latency on an empty, idle FIFO: byte pushed at cycle N, IDLE→LAUNCH at N+1, `uart_tx_en` high during cycle N+2.
- Gap between back-to-back bytes: 2 cycles after `uart_tx_busy` falls (WAIT_FALL→IDLE→LAUNCH).
- `is_addr` and `is_data` in the same cycle: the data write uses the old select and the select updates afterwards.

## Structure
- Shared package `nanoV_mmio_pkg`: the three default addresses, status bit indices, and the FSM state enum.
- Sub-module `nanoV_sync_fifo` (parameterised width and depth; push/pop/full/empty/count), instantiated once at width 8.
- Everything else is flat.

## Test plan
- Reset then idle: `bus_in`=0, `led_data`=0, status read = 32'h8 (empty only).
- GPIO write: addr 32'h10000000, data `bus_out`=32'h00000001 → `led_data`=32'h80000000. Read with buttons=3'b101 → `bus_in`=32'h5.
- UART single byte: write to 32'h10001000 with `bus_out`=32'h82000000 (reversed 0x41). Expect `uart_tx_en` pulse 2 cycles after the write with `uart_tx_data`=8'h41, and status `tx_active`=1 until busy falls.
- Burst: 6 writes while the serialiser is held busy, `FIFO_DEPTH`=4. Expect 4 accepted, `fifo_full`=1, `ovf`=1. Bytes are emitted in order with one `uart_tx_en` per busy-low window. A write to the status address clears `ovf`.
- Full with simultaneous push and pop in the LAUNCH cycle: the push is accepted and `ovf` stays 0.
- `rst` asserted during WAIT_FALL with 3 queued bytes: next cycle FIFO empty, FSM IDLE, `uart_tx_en`=0, and no further pulses after busy falls.
